// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, field widths, the packet
// reader FSM encoding and the running parity helper. Also imported by the
// router register block, so keep changes backward compatible.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_LEN_W  = 6;
    localparam int ROUTER_ADDR_W = 2;

    // Header byte layout: {len[7:2], addr[1:0]}
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_LEN_LSB   = ROUTER_ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_REQ = 3'd1,
        HDR_CAP = 3'd2,
        BODY    = 3'd3,
        DONE    = 3'd4
    } rd_state_t;

    // Packet parity is the XOR fold of header and all payload bytes.
    function automatic logic [ROUTER_DATA_W-1:0] parity_fold(
        input logic [ROUTER_DATA_W-1:0] acc,
        input logic [ROUTER_DATA_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output FIFO.
// Reads a header {len, addr}, streams len payload bytes to the sink, then
// consumes and checks the trailing parity byte.
//
// Ports:
//   clock, resetn        clock (rising edge), asynchronous active-low reset
//   vld_out              FIFO non-empty
//   data_out             FIFO read data, valid the cycle after read_enb
//   soft_reset           router flushed this FIFO; abort the current packet
//   hold                 downstream stall; no new reads while high
//   read_enb             FIFO read strobe
//   byte_out/byte_valid  payload byte stream to the sink
//   pkt_len              length field of the current packet
//   pkt_done             one-cycle pulse after the parity byte is consumed
//   parity_err/addr_err  packet status, valid only with pkt_done
//   pkt_abort            one-cycle pulse when soft_reset kills a packet
module router_pkt_reader
    import router_pkg::*;
#(
    parameter int                DATA_W  = ROUTER_DATA_W,
    parameter int                LEN_W   = ROUTER_LEN_W,
    parameter int                ADDR_W  = ROUTER_ADDR_W,
    parameter logic [ADDR_W-1:0] PORT_ID = 2'b01
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    input  logic              hold,
    output logic              read_enb,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              addr_err,
    output logic              pkt_abort
);

    // One extra bit so len=63 plus the parity byte (64) fits.
    localparam int CNT_W = LEN_W + 1;

    rd_state_t         state_reg;
    rd_state_t         state_next;

    logic              rd_d_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  pkt_len_reg;
    logic [DATA_W-1:0] parity_acc_reg;
    logic [CNT_W-1:0]  total_reg;          // reads to issue in BODY
    logic [CNT_W-1:0]  issued_reg;         // reads issued in BODY
    logic [CNT_W-1:0]  remaining_cap_reg;  // bytes still to be captured
    logic [DATA_W-1:0] byte_out_reg;
    logic              byte_valid_reg;
    logic              parity_err_reg;
    logic              addr_err_reg;
    logic              pkt_abort_reg;

    logic              abort;
    logic              capture;
    logic [LEN_W-1:0]  hdr_len;
    logic [ADDR_W-1:0] hdr_addr;

    assign hdr_len  = data_out[HDR_LEN_LSB +: LEN_W];
    assign hdr_addr = data_out[HDR_ADDR_LSB +: ADDR_W];

    // soft_reset only matters once a packet has been started.
    assign abort   = soft_reset && (state_reg != IDLE);
    // A read issued last cycle lands now; in BODY it is payload or parity.
    assign capture = rd_d_reg && (state_reg == BODY);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        read_enb   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vld_out && !hold) begin
                    state_next = HDR_REQ;
                end
            end
            HDR_REQ: begin
                // Wait here if the FIFO drained or hold rose after IDLE.
                read_enb = vld_out && !hold;
                if (read_enb) begin
                    state_next = HDR_CAP;
                end
            end
            HDR_CAP: begin
                state_next = BODY;
            end
            BODY: begin
                read_enb = vld_out && !hold && (issued_reg < total_reg);
                if (capture && (remaining_cap_reg == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Never read from a FIFO that is being flushed.
        if (abort) begin
            state_next = IDLE;
            read_enb   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_d_reg          <= 1'b0;
            addr_reg          <= '0;
            pkt_len_reg       <= '0;
            parity_acc_reg    <= '0;
            total_reg         <= '0;
            issued_reg        <= '0;
            remaining_cap_reg <= '0;
            byte_out_reg      <= '0;
            byte_valid_reg    <= 1'b0;
            parity_err_reg    <= 1'b0;
            addr_err_reg      <= 1'b0;
            pkt_abort_reg     <= 1'b0;
        end else begin
            rd_d_reg       <= read_enb;
            byte_valid_reg <= 1'b0;
            pkt_abort_reg  <= abort;
            if (abort) begin
                // Drops any capture landing this cycle as well.
                total_reg         <= '0;
                issued_reg        <= '0;
                remaining_cap_reg <= '0;
                parity_acc_reg    <= '0;
            end else begin
                case (state_reg)
                    HDR_CAP: begin
                        pkt_len_reg       <= hdr_len;
                        addr_reg          <= hdr_addr;
                        parity_acc_reg    <= data_out;
                        total_reg         <= {1'b0, hdr_len} + CNT_W'(1);
                        remaining_cap_reg <= {1'b0, hdr_len} + CNT_W'(1);
                        issued_reg        <= '0;
                    end
                    BODY: begin
                        if (read_enb) begin
                            issued_reg <= issued_reg + CNT_W'(1);
                        end
                        if (capture) begin
                            remaining_cap_reg <= remaining_cap_reg - CNT_W'(1);
                            if (remaining_cap_reg > CNT_W'(1)) begin
                                byte_out_reg   <= data_out;
                                byte_valid_reg <= 1'b1;
                                parity_acc_reg <= parity_fold(parity_acc_reg, data_out);
                            end else begin
                                // Last capture is the parity byte itself.
                                parity_err_reg <= (parity_acc_reg != data_out);
                                addr_err_reg   <= (addr_reg != PORT_ID);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign byte_out   = byte_out_reg;
    assign byte_valid = byte_valid_reg;
    assign pkt_len    = pkt_len_reg;
    assign pkt_done   = (state_reg == DONE);
    assign parity_err = pkt_done && parity_err_reg;
    assign addr_err   = pkt_done && addr_err_reg;
    assign pkt_abort  = pkt_abort_reg;

endmodule

// File: tb/tb_router_pkt_reader.sv
`timescale 1ns/1ps
module tb_router_pkt_reader;
    import router_pkg::*;

    localparam logic [1:0] PORT = 2'b01;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       vld_out = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       soft_reset = 1'b0;
    logic       hold = 1'b0;
    logic       read_enb;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       addr_err;
    logic       pkt_abort;

    int checks = 0;
    int failures = 0;

    // FIFO model and scoreboard state
    logic [7:0] fifo_q[$];
    logic       starve = 1'b0;
    bit         fifo_take;
    logic [7:0] got_q[$];
    logic [7:0] exp_bytes[$];
    bit         exp_perr_q[$];
    bit         exp_aerr_q[$];
    logic [5:0] exp_len_q[$];
    logic [7:0] pl[$];
    int         done_cnt = 0;
    int         abort_cnt = 0;
    longint     cyc = 0;
    longint     rd_cycles[$];

    always #5 clock = ~clock;

    router_pkt_reader #(.PORT_ID(PORT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .soft_reset (soft_reset),
        .hold       (hold),
        .read_enb   (read_enb),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .pkt_abort  (pkt_abort)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // FIFO: a read sampled at a rising edge presents its data just after it.
    always @(posedge clock) begin
        fifo_take = read_enb;
        #1;
        if (fifo_take && fifo_q.size() > 0) data_out = fifo_q.pop_front();
        vld_out = (fifo_q.size() > 0) && !starve;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (resetn) begin
            if (hold || !vld_out) chk("rd_gate", 64'(read_enb), 64'(0));
            if (read_enb) rd_cycles.push_back(cyc);
            if (byte_valid) got_q.push_back(byte_out);
            if (pkt_abort) abort_cnt++;
            if (pkt_done) begin
                done_cnt++;
                chk("done_expected", 64'(exp_perr_q.size() != 0), 64'(1));
                if (exp_perr_q.size() != 0) begin
                    chk("parity_err", 64'(parity_err), 64'(exp_perr_q.pop_front()));
                    chk("addr_err", 64'(addr_err), 64'(exp_aerr_q.pop_front()));
                    chk("pkt_len", 64'(pkt_len), 64'(exp_len_q.pop_front()));
                end
            end else begin
                chk("flags_idle", 64'({parity_err, addr_err}), 64'(0));
            end
        end
    end

    task automatic make_payload(input int n);
        pl.delete();
        repeat (n) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference model: expected parity is the XOR of header and payload.
    task automatic push_pkt(input logic [7:0] hdr, input bit bad);
        logic [7:0] good;
        logic [7:0] sent;
        good = hdr;
        foreach (pl[i]) good ^= pl[i];
        sent = bad ? ~good : good;
        fifo_q.push_back(hdr);
        foreach (pl[i]) begin
            fifo_q.push_back(pl[i]);
            exp_bytes.push_back(pl[i]);
        end
        fifo_q.push_back(sent);
        exp_perr_q.push_back(sent != good);
        exp_aerr_q.push_back(hdr[1:0] != PORT);
        exp_len_q.push_back(hdr[7:2]);
    endtask

    task automatic clear_model();
        fifo_q.delete();
        got_q.delete();
        exp_bytes.delete();
        exp_perr_q.delete();
        exp_aerr_q.delete();
        exp_len_q.delete();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, 64'(got_q.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < got_q.size() && i < exp_bytes.size(); i++)
            chk({tag, "_byte"}, 64'(got_q[i]), 64'(exp_bytes[i]));
        chk({tag, "_all_done"}, 64'(exp_perr_q.size()), 64'(0));
        got_q.delete();
        exp_bytes.delete();
    endtask

    task automatic wait_done(input string tag, input int n, input int hold_after, input bit rstarve);
        int  target;
        bit  held;
        target = done_cnt + n;
        held = 1'b0;
        for (int c = 0; c < 4000 && done_cnt < target; c++) begin
            @(posedge clock); #1;
            starve = rstarve ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (!held && hold_after >= 0 && got_q.size() >= hold_after) begin
                held = 1'b1;
                hold = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    chk({tag, "_hold_rd"}, 64'(read_enb), 64'(0));
                    @(posedge clock); #1;
                end
                hold = 1'b0;
            end
        end
        starve = 1'b0;
        hold = 1'b0;
        chk({tag, "_done_in_time"}, 64'(done_cnt >= target), 64'(1));
        repeat (2) @(posedge clock);
        #1;
        check_stream(tag);
        $display("pkt %s: pkts=%0d checks=%0d failures=%0d", tag, n, checks, failures);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        for (int c = 0; c < 2000 && got_q.size() < n; c++) begin
            @(posedge clock); #1;
        end
        chk({tag, "_reach"}, 64'(got_q.size() >= n), 64'(1));
    endtask

    initial begin
        logic [7:0] hdr;
        int         d0;
        int         a0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_read_enb", 64'(read_enb), 64'(0));
        chk("rst_byte_valid", 64'(byte_valid), 64'(0));
        chk("rst_byte_out", 64'(byte_out), 64'(0));
        chk("rst_pkt_len", 64'(pkt_len), 64'(0));
        chk("rst_pkt_done", 64'(pkt_done), 64'(0));
        chk("rst_parity_err", 64'(parity_err), 64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
        chk("rst_pkt_abort", 64'(pkt_abort), 64'(0));
        $display("reset: checks=%0d failures=%0d", checks, failures);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Good packet, len 14 addr 01
        make_payload(14);
        push_pkt(8'h39, 1'b0);
        wait_done("good14", 1, -1, 1'b0);

        // Same payload, parity byte inverted
        push_pkt(8'h39, 1'b1);
        wait_done("badpar14", 1, -1, 1'b0);

        // len 0, addr 10: parity byte equals header
        make_payload(0);
        push_pkt(8'h02, 1'b0);
        wait_done("len0", 1, -1, 1'b0);

        // hold for 3 cycles after the 5th payload byte
        make_payload(14);
        push_pkt(8'h39, 1'b0);
        wait_done("hold14", 1, 5, 1'b0);

        // Random packets with random FIFO-empty gaps
        for (int k = 0; k < 4; k++) begin
            hdr = {6'($urandom_range(0, 20)), 2'($urandom_range(0, 3))};
            make_payload(int'(hdr[7:2]));
            push_pkt(hdr, 1'($urandom_range(0, 1)));
            wait_done("rand", 1, -1, 1'b1);
        end

        // soft_reset after 6 payload bytes
        make_payload(14);
        push_pkt(8'h39, 1'b0);
        wait_bytes("sreset", 6);
        for (int i = 0; i < 6; i++) chk("sreset_prefix", 64'(got_q[i]), 64'(exp_bytes[i]));
        d0 = done_cnt;
        a0 = abort_cnt;
        soft_reset = 1'b1;
        fifo_q.delete();
        vld_out = 1'b0;
        @(posedge clock); #1;
        soft_reset = 1'b0;
        @(negedge clock);
        chk("sreset_abort", 64'(pkt_abort), 64'(1));
        chk("sreset_idle", 64'(dut.state_reg), 64'(IDLE));
        chk("sreset_rd", 64'(read_enb), 64'(0));
        chk("sreset_bv", 64'(byte_valid), 64'(0));
        repeat (20) @(posedge clock);
        #1;
        chk("sreset_no_done", 64'(done_cnt), 64'(d0));
        chk("sreset_one_abort", 64'(abort_cnt), 64'(a0 + 1));
        clear_model();
        $display("sreset: checks=%0d failures=%0d", checks, failures);
        make_payload(1);
        push_pkt(8'h05, 1'b0);
        wait_done("after_sreset", 1, -1, 1'b0);

        // Back-to-back: len 63 then len 1
        rd_cycles.delete();
        make_payload(63);
        push_pkt(8'hFD, 1'b0);
        make_payload(1);
        push_pkt(8'h05, 1'b0);
        wait_done("b2b", 2, -1, 1'b0);
        chk("b2b_reads", 64'(rd_cycles.size()), 64'(68));
        if (rd_cycles.size() >= 66)
            chk("b2b_gap_min2", 64'((rd_cycles[65] - rd_cycles[64] - 1) >= 2), 64'(1));

        // Asynchronous reset mid-packet
        make_payload(14);
        push_pkt(8'h39, 1'b0);
        wait_bytes("areset", 3);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1;
        chk("areset_rd", 64'(read_enb), 64'(0));
        chk("areset_bv", 64'(byte_valid), 64'(0));
        chk("areset_len", 64'(pkt_len), 64'(0));
        chk("areset_idle", 64'(dut.state_reg), 64'(IDLE));
        clear_model();
        vld_out = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        $display("areset: checks=%0d failures=%0d", checks, failures);
        make_payload(2);
        push_pkt(8'h09, 1'b0);
        wait_done("after_areset", 1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_reader.md
Name: router_pkt_reader

Overview:
- Destination-side consumer for one router output port; drains packets from a router_fifo read interface.
- Parses header {len[7:2], addr[1:0]}, streams payload bytes to the downstream sink, checks the trailing parity byte, and reports per-packet status.
- One instance sits behind each of the three router output FIFOs, in the destination subsystem and in the system testbench.

Parameters:
- DATA_W, 8, byte width of FIFO data and header.
- LEN_W, 6, payload-length field width (header bits [7:2]).
- ADDR_W, 2, address field width (header bits [1:0]).
- PORT_ID, 2'b01, expected address for this port; a mismatch flags addr_err.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- vld_out  in  1  FIFO non-empty (~empty).
- data_out  in  DATA_W  FIFO read data, valid one cycle after read_enb.
- soft_reset  in  1  router flushed this FIFO (timeout); abort the current packet.
- hold  in  1  downstream stall; no new read issued while high.
- read_enb  out  1  FIFO read strobe.
- byte_out  out  DATA_W  payload byte to the sink.
- byte_valid  out  1  byte_out valid (payload bytes only).
- pkt_len  out  LEN_W  length of the current packet, from the header.
- pkt_done  out  1  one-cycle pulse when the parity byte is consumed.
- parity_err  out  1  valid with pkt_done; computed parity != received parity.
- addr_err  out  1  valid with pkt_done; header addr != PORT_ID.
- pkt_abort  out  1  one-cycle pulse when soft_reset kills an in-flight packet.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and parity accumulator 0.
- Read latency: data_out captured on the cycle after read_enb=1. rd_d is read_enb delayed one cycle.
- read_enb is never asserted when vld_out=0, when hold=1, or in IDLE/HDR_CAP/DONE.
- States:
  - IDLE -> HDR_REQ when vld_out=1 and hold=0.
  - HDR_REQ: read_enb=1 for exactly 1 cycle -> HDR_CAP.
  - HDR_CAP: latch pkt_len=data_out[7:2] and addr=data_out[1:0]; parity_acc=data_out; remaining=len+1 (payload + parity); issued=0 -> BODY.
  - BODY: read_enb = vld_out & ~hold & (issued < remaining). Each rd_d capture decrements remaining_cap.
    - While remaining_cap > 1: byte_out=data_out, byte_valid=1, parity_acc ^= data_out.
    - When remaining_cap == 1: the byte is parity; parity_err = (parity_acc != data_out) -> DONE.
  - DONE: pkt_done=1, parity_err/addr_err held for this cycle only -> IDLE.
- Counters are LEN_W+1 bits wide; len=63 gives remaining=64 with no overflow.
- len=0: HDR_CAP -> BODY; exactly one read is issued and that byte is parity; byte_valid never asserts; parity_err=(header!=parity).
- hold asserted mid-packet: read_enb drops the same cycle. An outstanding read issued the previous cycle is still captured. Resume on hold=0 with no byte lost or duplicated.
- FIFO empty mid-packet (vld_out=0): stall identically to hold.
- soft_reset in any non-IDLE state: next cycle FSM=IDLE, read_enb=0, byte_valid=0, pkt_abort=1 for 1 cycle, no pkt_done. Any in-flight rd_d capture is discarded. soft_reset in IDLE: no effect.
- Back-to-back packets: DONE -> IDLE -> HDR_REQ gives a minimum 2-cycle gap between the parity read and the next header read.
- Asynchronous reset mid-packet: immediate return to reset values.

Decomposition:
- Shared package router_pkg: header field positions, LEN_W/ADDR_W, FSM state encoding (IDLE, HDR_REQ, HDR_CAP, BODY, DONE), parity function (XOR fold). The same package is reused by the router register block.
- Single module; no sub-module is needed. The byte/parity counter stays inline.

Test Plan:
- Header 8'h39 (len 14, addr 01), 14 random payload bytes, correct parity -> 14 byte_valid pulses in order; pkt_done=1; parity_err=0; addr_err=0.
- Same packet with parity byte inverted -> pkt_done=1, parity_err=1, payload stream unchanged.
- Header 8'h02 (len 0, addr 10), parity 8'h02, PORT_ID=01 -> byte_valid never asserts; pkt_done with parity_err=0, addr_err=1.
- hold high 3 cycles after the 5th payload byte -> read_enb=0 during hold; exactly 14 bytes delivered, no duplicates.
- soft_reset pulse after 6 payload bytes -> pkt_abort=1 next cycle, no pkt_done, FSM IDLE. Next packet 8'h05 is read correctly.
- Two packets (len 63 then len 1) back to back -> 63 then 1 payload bytes; two pkt_done pulses; 2-cycle inter-packet gap.
